wave_rom_sched: RTL and testbench

Controller for the 8-channel wave sample player bank.
- Owns the free-running interleave slot counter and time-multiplexes the single wave ROM port between channels.
- Accepts play/stop commands from the CPU side through a small command FIFO and converts them into per-channel trigger and stop signalling.
- Allocates a free voice automatically when asked.
- Sits between the CPU/sound-register logic and the bank of wave_sound players plus the shared wave ROM.

---
 rtl/wave_pkg.sv | 26 ++
 rtl/wave_cmd_fifo.sv | 59 +++++
 rtl/wave_rom_sched.sv | 211 +++++++++++++++++++++
 tb/tb_wave_rom_sched.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the wave sample player bank controller.
// Holds the bank geometry, the controller FSM state encoding and the
// layout of one queued CPU command.
package wave_pkg;

  localparam int NCHAN  = 8;   // player channels; slot encoding assumes 8
  localparam int AW     = 17;  // ROM byte-address width
  localparam int SLOT_W = 4;   // interleave slot counter width (2 slots per channel)
  localparam int CHAN_W = 3;   // channel index width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    TRIG  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // One queued command. auto_sel asks the allocator to pick the channel.
  typedef struct packed {
    logic              stop;
    logic              auto_sel;
    logic [CHAN_W-1:0] chan;
    logic [AW-1:0]     addr;
  } cmd_t;

endpackage

// File: rtl/wave_cmd_fifo.sv
// Small synchronous command FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      write request and data; ignored while full
//   pop              read request; ignored while empty
//   rdata            head entry (valid while empty is low)
//   full, empty      occupancy flags
// There is no bypass path: a push into an empty FIFO is visible one clock later.
module wave_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4    // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr_reg];

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wave_rom_sched.sv
// Controller for the 8-channel wave sample player bank.
// Owns the interleave slot counter, time-multiplexes the shared wave ROM
// port, and turns queued CPU play/stop commands into per-channel trigger
// and stop levels, allocating a free voice on request.
// Ports:
//   I_CLK, I_RSTn              clock, asynchronous active-low reset
//   I_CMD_*, O_CMD_READY       command push interface (ready = FIFO not full)
//   I_CH_ACTIVE, I_CH_ADDR     per-channel status / ROM address from players
//   O_H_CNT                    slot counter; channel k owns slots 2k, 2k+1
//   O_TRIG, O_TRIG_ADDR        one-hot trigger level and its start address
//   O_STOP                     per-channel stop request levels
//   O_ROM_ADDR, I_ROM_DATA     shared ROM port (1-clock read latency)
//   O_CH_DATA                  ROM data broadcast to all players
//   O_LAST_CHAN                channel of the most recently issued play
module wave_rom_sched
  import wave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TRIG_CYC   = 2
) (
  input  logic                I_CLK,
  input  logic                I_RSTn,
  input  logic                I_CMD_VALID,
  output logic                O_CMD_READY,
  input  logic                I_CMD_STOP,
  input  logic                I_CMD_AUTO,
  input  logic [CHAN_W-1:0]   I_CMD_CHAN,
  input  logic [AW-1:0]       I_CMD_ADDR,
  input  logic [NCHAN-1:0]    I_CH_ACTIVE,
  input  logic [NCHAN*AW-1:0] I_CH_ADDR,
  output logic [SLOT_W-1:0]   O_H_CNT,
  output logic [NCHAN-1:0]    O_TRIG,
  output logic [AW-1:0]       O_TRIG_ADDR,
  output logic [NCHAN-1:0]    O_STOP,
  output logic [AW-1:0]       O_ROM_ADDR,
  input  logic [7:0]          I_ROM_DATA,
  output logic [7:0]          O_CH_DATA,
  output logic [CHAN_W-1:0]   O_LAST_CHAN
);

  localparam int TCW = $clog2(TRIG_CYC + 1);

  // Slot counter and ROM address mux
  logic [SLOT_W-1:0] h_cnt_reg;
  logic [SLOT_W-1:0] h_cnt_next;
  logic [AW-1:0]     rom_addr_reg;
  logic [AW-1:0]     ch_addr_arr [NCHAN];

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_ch_addr
      assign ch_addr_arr[gi] = I_CH_ADDR[gi*AW +: AW];
    end
  endgenerate

  assign h_cnt_next = h_cnt_reg + 1'b1;

  // The address is captured on the edge entering the even (address) slot
  // and held through the odd (data) slot, independent of channel activity.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      h_cnt_reg    <= '0;
      rom_addr_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      if (!h_cnt_next[0]) rom_addr_reg <= ch_addr_arr[h_cnt_next[SLOT_W-1:1]];
    end
  end

  // Command FIFO
  logic [$bits(cmd_t)-1:0] fifo_wdata;
  logic [$bits(cmd_t)-1:0] fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  cmd_t                    head_cmd;

  assign fifo_wdata = {I_CMD_STOP, I_CMD_AUTO, I_CMD_CHAN, I_CMD_ADDR};
  assign head_cmd   = cmd_t'(fifo_rdata);

  wave_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (I_CLK),
    .rst_n (I_RSTn),
    .push  (I_CMD_VALID),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Control state
  state_t             state_reg, state_next;
  logic [TCW-1:0]     trig_cnt_reg;
  logic [NCHAN-1:0]   trig_reg;
  logic [AW-1:0]      trig_addr_reg;
  logic [NCHAN-1:0]   stop_reg;
  logic [CHAN_W-1:0]  last_chan_reg;
  logic [CHAN_W-1:0]  rr_reg;
  logic [AW-1:0]      pend_addr_reg;

  logic               trig_enter;
  logic [CHAN_W-1:0]  enter_chan;
  logic [AW-1:0]      enter_addr;
  logic [NCHAN-1:0]   stop_set;
  logic               rr_adv;
  logic               free_found;
  logic [CHAN_W-1:0]  free_chan;

  // Lowest idle channel that is not already being stopped. Scanning
  // downwards lets the lowest index overwrite any higher match.
  always_comb begin
    free_found = 1'b0;
    free_chan  = '0;
    for (int k = NCHAN - 1; k >= 0; k--) begin
      if (!I_CH_ACTIVE[k] && !stop_reg[k]) begin
        free_found = 1'b1;
        free_chan  = CHAN_W'(k);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    trig_enter = 1'b0;
    enter_chan = '0;
    enter_addr = pend_addr_reg;
    stop_set   = '0;
    rr_adv     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_cmd.stop) begin
            stop_set = NCHAN'(1) << head_cmd.chan;
          end else if (head_cmd.auto_sel) begin
            state_next = ALLOC;
          end else begin
            state_next = TRIG;
            trig_enter = 1'b1;
            enter_chan = head_cmd.chan;
            enter_addr = head_cmd.addr;
          end
        end
      end
      ALLOC: begin
        state_next = TRIG;
        trig_enter = 1'b1;
        if (free_found) begin
          enter_chan = free_chan;
        end else begin
          enter_chan = rr_reg;
          rr_adv     = 1'b1;
        end
      end
      TRIG: begin
        if (trig_cnt_reg == TCW'(TRIG_CYC - 1)) state_next = GAP;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_reg     <= IDLE;
      trig_cnt_reg  <= '0;
      trig_reg      <= '0;
      trig_addr_reg <= '0;
      stop_reg      <= '0;
      last_chan_reg <= '0;
      rr_reg        <= '0;
      pend_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) pend_addr_reg <= head_cmd.addr;
      if (rr_adv)   rr_reg <= rr_reg + 1'b1;

      if (trig_enter) begin
        trig_reg      <= NCHAN'(1) << enter_chan;
        trig_addr_reg <= enter_addr;
        last_chan_reg <= enter_chan;
        trig_cnt_reg  <= '0;
      end else if (state_reg == TRIG) begin
        trig_cnt_reg <= trig_cnt_reg + 1'b1;
        if (state_next == GAP) trig_reg <= '0;
      end

      // Stop levels drop once the player reports idle; a new play to the
      // channel also cancels a pending stop.
      stop_reg <= ((stop_reg & I_CH_ACTIVE) | stop_set)
                  & ~(trig_enter ? (NCHAN'(1) << enter_chan) : NCHAN'(0));
    end
  end

  assign O_CMD_READY = ~fifo_full;
  assign O_H_CNT     = h_cnt_reg;
  assign O_ROM_ADDR  = rom_addr_reg;
  assign O_CH_DATA   = I_ROM_DATA;
  assign O_TRIG      = trig_reg;
  assign O_TRIG_ADDR = trig_addr_reg;
  assign O_STOP      = stop_reg;
  assign O_LAST_CHAN = last_chan_reg;

endmodule

// File: tb/tb_wave_rom_sched.sv
// Directed testbench for wave_rom_sched: slot counter / ROM mux, play,
// back-to-back retrigger, auto allocation and stealing, stop handling,
// FIFO full behaviour and reset in the middle of a trigger.
module tb_wave_rom_sched;
  import wave_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_stop;
  logic              cmd_auto;
  logic [2:0]        cmd_chan;
  logic [AW-1:0]     cmd_addr;
  logic [NCHAN-1:0]  ch_active;
  logic [NCHAN*AW-1:0] ch_addr;
  logic [3:0]        h_cnt;
  logic [NCHAN-1:0]  trig;
  logic [AW-1:0]     trig_addr;
  logic [NCHAN-1:0]  stop;
  logic [AW-1:0]     rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        ch_data;
  logic [2:0]        last_chan;

  always #5 clk = ~clk;

  wave_rom_sched #(.FIFO_DEPTH(4), .TRIG_CYC(2)) dut (
    .I_CLK       (clk),
    .I_RSTn      (rst_n),
    .I_CMD_VALID (cmd_valid),
    .O_CMD_READY (cmd_ready),
    .I_CMD_STOP  (cmd_stop),
    .I_CMD_AUTO  (cmd_auto),
    .I_CMD_CHAN  (cmd_chan),
    .I_CMD_ADDR  (cmd_addr),
    .I_CH_ACTIVE (ch_active),
    .I_CH_ADDR   (ch_addr),
    .O_H_CNT     (h_cnt),
    .O_TRIG      (trig),
    .O_TRIG_ADDR (trig_addr),
    .O_STOP      (stop),
    .O_ROM_ADDR  (rom_addr),
    .I_ROM_DATA  (rom_data),
    .O_CH_DATA   (ch_data),
    .O_LAST_CHAN (last_chan)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Trigger edge log: one entry per rising O_TRIG bit, sampled on negedge.
  int            cyc = 0;
  logic [7:0]    trig_prev = '0;
  int            multi_hot = 0;
  int            log_chan[$];
  int            log_cyc[$];
  logic [AW-1:0] log_addr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < NCHAN; k++) begin
      if (trig[k] && !trig_prev[k]) begin
        log_chan.push_back(k);
        log_cyc.push_back(cyc);
        log_addr.push_back(trig_addr);
      end
    end
    if ($countones(trig) > 1) multi_hot <= multi_hot + 1;
    trig_prev <= trig;
  end

  task automatic push_cmd(input logic s, input logic a, input logic [2:0] c, input logic [AW-1:0] ad);
    cmd_valid = 1'b1;
    cmd_stop  = s;
    cmd_auto  = a;
    cmd_chan  = c;
    cmd_addr  = ad;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] chan_addr_val(input int k);
    return 32'h100 * k + k;
  endfunction

  int base;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_stop  = 1'b0;
    cmd_auto  = 1'b0;
    cmd_chan  = '0;
    cmd_addr  = '0;
    ch_active = '0;
    rom_data  = '0;
    for (int k = 0; k < NCHAN; k++) ch_addr[k*AW +: AW] = AW'(chan_addr_val(k));

    // Reset state
    idle(2);
    check_val("rst_h_cnt", h_cnt, 0);
    check_val("rst_trig", trig, 0);
    check_val("rst_stop", stop, 0);
    check_val("rst_trig_addr", trig_addr, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_last_chan", last_chan, 0);
    check_val("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // 1: slot counter wrap, ROM mux ownership, data pass-through
    for (int i = 0; i < 20; i++) begin
      rom_data = 8'(i * 7 + 3);
      #1;
      check_val($sformatf("t1_h_cnt_%0d", i), h_cnt, i % 16);
      check_val($sformatf("t1_rom_addr_%0d", i), rom_addr, chan_addr_val((i % 16) / 2));
      check_val($sformatf("t1_ch_data_%0d", i), ch_data, (i * 7 + 3) % 256);
      @(negedge clk);
    end
    $display("t1 slot sweep done");

    // 2: single play to channel 2
    push_cmd(1'b0, 1'b0, 3'd2, 17'h01000);
    check_val("t2_pre", trig, 0);
    idle(1);
    check_val("t2_trig_a", trig, 8'b0000_0100);
    check_val("t2_trig_addr", trig_addr, 17'h01000);
    check_val("t2_last_chan", last_chan, 2);
    idle(1);
    check_val("t2_trig_b", trig, 8'b0000_0100);
    idle(1);
    check_val("t2_gap", trig, 0);
    idle(1);
    check_val("t2_idle", trig, 0);
    $display("t2 play chan2 done");

    // 3: back-to-back plays to channel 5
    base = log_chan.size();
    push_cmd(1'b0, 1'b0, 3'd5, 17'h02000);
    push_cmd(1'b0, 1'b0, 3'd5, 17'h02100);
    idle(12);
    check_val("t3_edges", log_chan.size() - base, 2);
    if (log_chan.size() - base == 2) begin
      check_val("t3_chan_a", log_chan[base], 5);
      check_val("t3_chan_b", log_chan[base+1], 5);
      check_val("t3_spacing", log_cyc[base+1] - log_cyc[base], 4);
      check_val("t3_addr_b", log_addr[base+1], 17'h02100);
    end
    $display("t3 retrigger done");

    // 4: auto allocation, then stealing with every channel active
    ch_active = 8'b0000_0111;
    base = log_chan.size();
    push_cmd(1'b0, 1'b1, 3'd6, 17'h03000);
    idle(8);
    check_val("t4_alloc_edges", log_chan.size() - base, 1);
    if (log_chan.size() - base == 1) begin
      check_val("t4_alloc_chan", log_chan[base], 3);
      check_val("t4_alloc_addr", log_addr[base], 17'h03000);
    end
    ch_active = 8'hFF;
    base = log_chan.size();
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 1'b1, 3'd7, AW'(17'h03100 + i));
    idle(25);
    check_val("t4_steal_edges", log_chan.size() - base, 4);
    if (log_chan.size() - base == 4) begin
      for (int i = 0; i < 4; i++) check_val($sformatf("t4_steal_%0d", i), log_chan[base+i], i);
    end
    $display("t4 alloc/steal done");

    // 5: stop handling
    push_cmd(1'b1, 1'b0, 3'd4, '0);
    idle(1);
    check_val("t5_stop_set", stop, 8'h10);
    idle(3);
    check_val("t5_stop_hold", stop, 8'h10);
    ch_active[4] = 1'b0;
    #1;
    check_val("t5_stop_before_edge", stop, 8'h10);
    idle(1);
    check_val("t5_stop_clear", stop, 0);
    push_cmd(1'b1, 1'b0, 3'd4, '0);
    idle(1);
    check_val("t5_inact_set", stop, 8'h10);
    idle(1);
    check_val("t5_inact_clear", stop, 0);
    ch_active[4] = 1'b1;
    push_cmd(1'b1, 1'b0, 3'd4, '0);
    push_cmd(1'b0, 1'b0, 3'd4, 17'h04000);
    check_val("t5_play_stop_set", stop, 8'h10);
    idle(1);
    check_val("t5_play_stop_clr", stop, 0);
    check_val("t5_play_trig", trig, 8'h10);
    idle(5);
    $display("t5 stop done");

    // 6a: FIFO fills while the first play is in TRIG; 6th push ignored
    ch_active = '0;
    idle(2);
    base = log_chan.size();
    for (int i = 1; i <= 4; i++) push_cmd(1'b0, 1'b0, 3'(i), AW'(17'h05000 + i));
    check_val("t6_ready_3", cmd_ready, 1);
    push_cmd(1'b0, 1'b0, 3'd5, 17'h05005);
    check_val("t6_ready_full", cmd_ready, 0);
    push_cmd(1'b0, 1'b0, 3'd6, 17'h05006);
    idle(30);
    check_val("t6_edges", log_chan.size() - base, 5);
    if (log_chan.size() - base == 5) begin
      for (int i = 0; i < 5; i++) check_val($sformatf("t6_chan_%0d", i), log_chan[base+i], i + 1);
    end
    check_val("t6_ready_drained", cmd_ready, 1);
    $display("t6a fifo full done");

    // 6b: reset while a trigger is high and commands are queued
    base = log_chan.size();
    push_cmd(1'b0, 1'b0, 3'd7, 17'h06000);
    push_cmd(1'b0, 1'b0, 3'd6, 17'h06100);
    push_cmd(1'b0, 1'b0, 3'd5, 17'h06200);
    check_val("t6_mid_trig", trig, 8'h80);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_trig", trig, 0);
    check_val("t6_rst_ready", cmd_ready, 1);
    check_val("t6_rst_last", last_chan, 0);
    check_val("t6_rst_taddr", trig_addr, 0);
    check_val("t6_rst_h_cnt", h_cnt, 0);
    idle(2);
    rst_n = 1'b1;
    idle(12);
    check_val("t6_post_edges", log_chan.size() - base, 1);
    check_val("t6_post_trig", trig, 0);
    check_val("t6_post_last", last_chan, 0);
    $display("t6b reset mid-trigger done");

    check_val("onehot_trig", multi_hot, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
